// File: rtl/mem_arbiter_if.sv
// Bundle of fetcher, accessor and native-memory signals around mem_arbiter.
// The master view belongs to the arbiter; the slave view belongs to the requesters and memory.
interface mem_arbiter_if;
   logic        i_valid;
   logic [31:0] i_addr;
   logic        i_ready;
   logic [31:0] i_rdata;
   logic        d_valid;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_wstrb;
   logic        d_ready;
   logic [31:0] d_rdata;
   logic        err;
   logic        mem_valid;
   logic        mem_instr;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;

   modport master (
      input  i_valid, i_addr, d_valid, d_addr, d_wdata, d_wstrb, mem_ready, mem_rdata,
      output i_ready, i_rdata, d_ready, d_rdata, err,
             mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb
   );

   modport slave (
      output i_valid, i_addr, d_valid, d_addr, d_wdata, d_wstrb, mem_ready, mem_rdata,
      input  i_ready, i_rdata, d_ready, d_rdata, err,
             mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one native memory port between the instruction fetcher and the data accessor.
// Data wins by default; a streak guard and a hung-access timeout keep both sides moving.
module mem_arbiter #(
   parameter int MAX_DATA_BURST = 4,
   parameter int TIMEOUT        = 1024
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.master bus
);

   typedef enum logic [1:0] {IDLE, INSTR, DATA} state_t;

   localparam logic [3:0]  BURST_LIMIT  = 4'(MAX_DATA_BURST);
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
   localparam bit          TIMEOUT_EN   = (TIMEOUT != 0);

   state_t      r_state;
   logic [3:0]  r_streak;
   logic [15:0] r_toCount;

   logic        w_turnaround;
   logic        w_iReq;
   logic        w_dReq;
   logic        w_grantData;
   logic        w_timeout;
   logic        w_done;
   logic [31:0] w_rdata;

   // The completion cycle is a turnaround: the finishing requester still shows its old
   // request, so nobody is granted until both readies are low again.
   assign w_turnaround = bus.i_ready | bus.d_ready;
   assign w_iReq       = bus.i_valid & ~w_turnaround;
   assign w_dReq       = bus.d_valid & ~w_turnaround;
   assign w_grantData  = w_dReq & (~w_iReq | (r_streak < BURST_LIMIT));
   assign w_timeout    = TIMEOUT_EN && (r_toCount == TIMEOUT_LAST);
   assign w_done       = bus.mem_ready | w_timeout;
   assign w_rdata      = bus.mem_ready ? bus.mem_rdata : 32'd0;

   // Arbitration, bus hold, completion and timeout abort; all outputs registered.
   // A real answer arriving on the last allowed cycle beats the timeout.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= IDLE;
         r_streak      <= '0;
         r_toCount     <= '0;
         bus.i_ready   <= 1'b0;
         bus.i_rdata   <= '0;
         bus.d_ready   <= 1'b0;
         bus.d_rdata   <= '0;
         bus.err       <= 1'b0;
         bus.mem_valid <= 1'b0;
         bus.mem_instr <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.mem_wstrb <= '0;
      end else begin
         bus.i_ready <= 1'b0;
         bus.d_ready <= 1'b0;
         bus.err     <= 1'b0;
         case (r_state)
            IDLE: begin
               r_toCount <= '0;
               if (w_grantData) begin
                  r_state       <= DATA;
                  r_streak      <= w_iReq ? r_streak + 4'd1 : 4'd0;
                  bus.mem_valid <= 1'b1;
                  bus.mem_instr <= 1'b0;
                  bus.mem_addr  <= bus.d_addr;
                  bus.mem_wdata <= bus.d_wdata;
                  bus.mem_wstrb <= bus.d_wstrb;
               end else if (w_iReq) begin
                  r_state       <= INSTR;
                  r_streak      <= '0;
                  bus.mem_valid <= 1'b1;
                  bus.mem_instr <= 1'b1;
                  bus.mem_addr  <= bus.i_addr;
                  bus.mem_wdata <= '0;
                  bus.mem_wstrb <= '0;
               end
            end
            INSTR, DATA: begin
               if (w_done) begin
                  r_state       <= IDLE;
                  r_toCount     <= '0;
                  bus.mem_valid <= 1'b0;
                  bus.err       <= ~bus.mem_ready;
                  if (r_state == INSTR) begin
                     bus.i_ready <= 1'b1;
                     bus.i_rdata <= w_rdata;
                  end else begin
                     bus.d_ready <= 1'b1;
                     bus.d_rdata <= w_rdata;
                  end
               end else begin
                  r_toCount <= r_toCount + 16'd1;
               end
            end
            default: begin
               r_state       <= IDLE;
               bus.mem_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter, checked every cycle against a
// transaction-level model of the arbitration, completion and timeout rules.
module tb_mem_arbiter;

   localparam int MAX_BURST = 4;
   localparam int TO_CYCLES = 8;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   mem_arbiter_if bus();

   mem_arbiter #(
      .MAX_DATA_BURST(MAX_BURST),
      .TIMEOUT       (TO_CYCLES)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          lat;
      logic [31:0] rdata;
   } req_t;

   typedef struct {
      logic        memValid;
      logic        memInstr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        iReady;
      logic        dReady;
      logic        err;
      logic [31:0] iRdata;
      logic [31:0] dRdata;
   } expect_t;

   req_t        fetchQ[$];
   req_t        dataQ[$];
   bit          grantLog[$];
   int          memAge;
   int          curLat;
   logic [31:0] curData;
   bit          noiseEn;
   logic        capInstr;
   logic [31:0] capAddr;
   logic [31:0] capWdata;
   logic [3:0]  capWstrb;
   int          checks = 0;
   int          passes = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
   endtask

   // Reference: who owns the bus, how long the memory has stalled, and how many data
   // grants have jumped a waiting fetch. Outputs predicted for the cycle after each edge.
   expect_t mdl;
   int      owner;
   int      waited;
   int      dataRun;
   bit      completing;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mdl     = '{default: '0};
         owner   = 0;
         waited  = 0;
         dataRun = 0;
      end else begin
         completing = mdl.iReady || mdl.dReady;
         mdl.iReady = 1'b0;
         mdl.dReady = 1'b0;
         mdl.err    = 1'b0;
         if (owner == 0) begin
            if (!completing && bus.d_valid && (!bus.i_valid || dataRun < MAX_BURST)) begin
               owner        = 2;
               waited       = 0;
               dataRun      = bus.i_valid ? dataRun + 1 : 0;
               mdl.memValid = 1'b1;
               mdl.memInstr = 1'b0;
               mdl.addr     = bus.d_addr;
               mdl.wdata    = bus.d_wdata;
               mdl.wstrb    = bus.d_wstrb;
            end else if (!completing && bus.i_valid) begin
               owner        = 1;
               waited       = 0;
               dataRun      = 0;
               mdl.memValid = 1'b1;
               mdl.memInstr = 1'b1;
               mdl.addr     = bus.i_addr;
               mdl.wdata    = '0;
               mdl.wstrb    = '0;
            end
         end else if (bus.mem_ready || (TO_CYCLES > 0 && waited + 1 == TO_CYCLES)) begin
            mdl.err      = !bus.mem_ready;
            mdl.memValid = 1'b0;
            if (owner == 1) begin
               mdl.iReady = 1'b1;
               mdl.iRdata = bus.mem_ready ? bus.mem_rdata : 32'd0;
            end else begin
               mdl.dReady = 1'b1;
               mdl.dRdata = bus.mem_ready ? bus.mem_rdata : 32'd0;
            end
            owner = 0;
         end else begin
            waited++;
         end
      end
   end

   // Every-cycle comparison against the model, on the inactive edge.
   always @(negedge clk) begin
      check("memValid", bus.mem_valid, mdl.memValid);
      if (mdl.memValid) begin
         check("memInstr", bus.mem_instr, mdl.memInstr);
         check("memAddr",  bus.mem_addr,  mdl.addr);
         check("memWdata", bus.mem_wdata, mdl.wdata);
         check("memWstrb", bus.mem_wstrb, mdl.wstrb);
      end
      check("iReady", bus.i_ready, mdl.iReady);
      check("dReady", bus.d_ready, mdl.dReady);
      check("err",    bus.err,     mdl.err);
      if (mdl.iReady) check("iRdata", bus.i_rdata, mdl.iRdata);
      if (mdl.dReady) check("dRdata", bus.d_rdata, mdl.dRdata);
   end

   // One clock of requester and memory behaviour: requesters retire on their ready and
   // present the next queued item; memory answers after the latency of the served item.
   task automatic tick();
      @(posedge clk);
      #1;
      if (bus.i_ready && fetchQ.size() > 0) fetchQ.delete(0);
      if (bus.d_ready && dataQ.size() > 0) dataQ.delete(0);
      bus.i_valid = (fetchQ.size() > 0);
      if (fetchQ.size() > 0) bus.i_addr = fetchQ[0].addr;
      bus.d_valid = (dataQ.size() > 0);
      if (dataQ.size() > 0) begin
         bus.d_addr  = dataQ[0].addr;
         bus.d_wdata = dataQ[0].wdata;
         bus.d_wstrb = dataQ[0].wstrb;
      end
      if (bus.mem_valid) begin
         if (memAge == 0) begin
            grantLog.push_back(bus.mem_instr);
            curLat  = 0;
            curData = $urandom();
            if (bus.mem_instr && fetchQ.size() > 0) begin
               curLat  = fetchQ[0].lat;
               curData = fetchQ[0].rdata;
            end else if (!bus.mem_instr && dataQ.size() > 0) begin
               curLat  = dataQ[0].lat;
               curData = dataQ[0].rdata;
            end
         end
         bus.mem_ready = (memAge == curLat);
         bus.mem_rdata = bus.mem_ready ? curData : $urandom();
         memAge++;
      end else begin
         memAge        = 0;
         bus.mem_ready = noiseEn && ($urandom_range(0, 3) == 0);
         bus.mem_rdata = $urandom();
      end
   endtask

   task automatic waitReady(input bit isData, output bit gotErr, output logic [31:0] gotData,
                            output int validCycles);
      bit ok;
      ok          = 1'b0;
      gotErr      = 1'b0;
      gotData     = '0;
      validCycles = 0;
      for (int n = 0; n < 200; n++) begin
         tick();
         if (bus.mem_valid) begin
            if (validCycles == 0) begin
               capInstr = bus.mem_instr;
               capAddr  = bus.mem_addr;
               capWdata = bus.mem_wdata;
               capWstrb = bus.mem_wstrb;
            end
            validCycles++;
         end
         if (isData ? bus.d_ready : bus.i_ready) begin
            ok      = 1'b1;
            gotErr  = bus.err;
            gotData = isData ? bus.d_rdata : bus.i_rdata;
            break;
         end
      end
      check(isData ? "dataReadyArrives" : "fetchReadyArrives", ok, 1);
   endtask

   function automatic req_t randReq(input bit isData);
      req_t r;
      int   pick;
      pick    = $urandom_range(0, 11);
      r.addr  = $urandom();
      r.wdata = isData ? $urandom() : 32'd0;
      r.wstrb = isData ? 4'($urandom_range(0, 15)) : 4'd0;
      r.lat   = (pick == 0) ? 255 : (pick == 1) ? 7 : pick % 4;
      r.rdata = $urandom();
      return r;
   endfunction

   task automatic checkGrantOrder(input string tag, input int count, input bit pattern[]);
      logic act;
      for (int k = 0; k < count; k++) begin
         act = (grantLog.size() > k) ? logic'(grantLog[k]) : 1'bx;
         check($sformatf("%s%0d", tag, k), act, pattern[k]);
      end
   endtask

   bit          e;
   logic [31:0] d;
   int          vc;
   int          pulses;
   bit          orderA[] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
   bit          orderB[] = '{0, 0, 0, 0, 1};

   initial begin
      bus.i_valid   = 0;
      bus.i_addr    = 0;
      bus.d_valid   = 0;
      bus.d_addr    = 0;
      bus.d_wdata   = 0;
      bus.d_wstrb   = 0;
      bus.mem_ready = 0;
      bus.mem_rdata = 0;
      noiseEn       = 0;
      memAge        = 0;
      repeat (3) @(posedge clk);
      #1;
      check("resetMemValid", bus.mem_valid, 0);
      check("resetIReady",   bus.i_ready,   0);
      check("resetDReady",   bus.d_ready,   0);
      check("resetErr",      bus.err,       0);
      check("resetMemAddr",  bus.mem_addr,  0);
      reset = 1'b1;

      fetchQ.push_back('{32'h100, 32'h0, 4'h0, 2, 32'h0000_0013});
      waitReady(0, e, d, vc);
      check("fetchInstr", capInstr, 1);
      check("fetchAddr",  capAddr,  32'h100);
      check("fetchWstrb", capWstrb, 0);
      check("fetchRdata", d,        32'h13);
      check("fetchErr",   e,        0);
      check("fetchValidCycles", vc, 3);

      dataQ.push_back('{32'h2004, 32'hDEAD_BEEF, 4'hF, 0, 32'h0});
      waitReady(1, e, d, vc);
      check("storeInstr", capInstr, 0);
      check("storeAddr",  capAddr,  32'h2004);
      check("storeWdata", capWdata, 32'hDEAD_BEEF);
      check("storeWstrb", capWstrb, 4'hF);
      check("storeValidCycles", vc, 1);
      check("storeErr", e, 0);
      tick();
      check("storeReadyOneCycle", bus.d_ready, 0);

      dataQ.push_back('{32'h3000, 32'h0, 4'h0, 255, 32'h5555_AAAA});
      waitReady(1, e, d, vc);
      check("timeoutValidCycles", vc, TO_CYCLES);
      check("timeoutErr",   e, 1);
      check("timeoutRdata", d, 0);
      fetchQ.push_back('{32'h104, 32'h0, 4'h0, 1, 32'h0010_0093});
      waitReady(0, e, d, vc);
      check("afterTimeoutErr",   e, 0);
      check("afterTimeoutRdata", d, 32'h0010_0093);

      dataQ.push_back('{32'h3008, 32'h0, 4'h0, TO_CYCLES - 1, 32'hCAFE_F00D});
      waitReady(1, e, d, vc);
      check("raceValidCycles", vc, TO_CYCLES);
      check("raceErr",   e, 0);
      check("raceRdata", d, 32'hCAFE_F00D);

      // Both requesters kept busy: data may jump a waiting fetch only MAX_BURST times.
      grantLog.delete();
      for (int k = 0; k < 10; k++) dataQ.push_back('{$urandom(), $urandom(), 4'hF, k % 3, $urandom()});
      for (int k = 0; k < 3; k++) fetchQ.push_back('{$urandom(), 32'h0, 4'h0, k, $urandom()});
      for (int n = 0; n < 400 && dataQ.size() > 0; n++) tick();
      check("contentionDrained", dataQ.size(), 0);
      checkGrantOrder("grantOrder", 10, orderA);
      for (int n = 0; n < 100 && fetchQ.size() > 0; n++) tick();

      // Abort a store that was granted past a waiting fetch, then confirm a clean restart.
      dataQ.push_back('{32'h4000, 32'h1234_5678, 4'h3, 255, 32'h0});
      fetchQ.push_back('{32'h200, 32'h0, 4'h0, 1, 32'h0});
      for (int n = 0; n < 20 && !bus.mem_valid; n++) tick();
      tick();
      #2;
      reset = 1'b0;
      #1;
      check("resetAbortMemValid", bus.mem_valid, 0);
      check("resetAbortDReady",   bus.d_ready,   0);
      dataQ.delete();
      fetchQ.delete();
      bus.d_valid   = 0;
      bus.i_valid   = 0;
      bus.mem_ready = 0;
      memAge        = 0;
      tick();
      tick();
      reset  = 1'b1;
      pulses = 0;
      repeat (6) begin
         tick();
         if (bus.d_ready || bus.i_ready) pulses++;
      end
      check("noPulseAfterAbort", pulses, 0);
      grantLog.delete();
      for (int k = 0; k < 5; k++) dataQ.push_back('{$urandom(), $urandom(), 4'h1, 0, $urandom()});
      for (int k = 0; k < 2; k++) fetchQ.push_back('{$urandom(), 32'h0, 4'h0, 0, $urandom()});
      for (int n = 0; n < 200 && (dataQ.size() > 0 || fetchQ.size() > 0); n++) tick();
      checkGrantOrder("postResetOrder", 5, orderB);

      noiseEn = 1;
      for (int n = 0; n < 600; n++) begin
         if (fetchQ.size() < 2 && $urandom_range(0, 3) == 0) fetchQ.push_back(randReq(0));
         if (dataQ.size() < 3 && $urandom_range(0, 2) == 0) dataQ.push_back(randReq(1));
         tick();
      end
      for (int n = 0; n < 800 && (dataQ.size() > 0 || fetchQ.size() > 0); n++) tick();
      check("randomDrained", dataQ.size() + fetchQ.size(), 0);
      noiseEn = 0;
      tick();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
